// File: rtl/parking_pkg.sv
// Shared definitions for the parking keypad entry block.
// Contents: entry-state enumeration, digit-code width, key count and a
// helper that turns a one-hot key event vector into its digit code.
package parking_pkg;

    localparam int unsigned DIGIT_W   = 2;
    localparam int unsigned KEY_COUNT = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Index of the (single) set bit; only meaningful for a one-hot input.
    function automatic logic [DIGIT_W-1:0] key_index(input logic [KEY_COUNT-1:0] keys);
        logic [DIGIT_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < KEY_COUNT; i++) begin
            if (keys[i]) idx = DIGIT_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/parking_debounce.sv
// Debouncer for one raw active-low button.
// Two-flop synchronizer, consecutive-cycle stability counter and falling-edge
// detect on the debounced level.
// Ports:
//   clock    - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   raw      - raw asynchronous button level (0 = pressed)
//   press    - one-cycle pulse when the debounced level goes high-to-low
module parking_debounce
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic             armed;
    logic [CNT_W-1:0] count;

    // The synchronizer resets to "pressed" and press events stay blocked until
    // a released level has been seen, so a button held through reset never
    // produces an event until it is released and pressed again.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            level  <= 1'b1;
            armed  <= 1'b0;
            count  <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2) armed <= 1'b1;
            if (sync_2 != level) begin
                if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync_2;
                    count <= '0;
                    press <= armed & ~sync_2;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/parking_keypad_entry.sv
// Two-digit parking keypad code entry.
// Four digit buttons and a clear button are debounced; single key presses
// fill password_1 then password_2, after which the code is offered with
// pw_valid until pw_ack accepts it.
// Optional feature macro: KEYPAD_TIMEOUT_EN (discard a half-entered code
// after TIMEOUT_CYCLES idle cycles and pulse timeout_pulse).
// Ports:
//   clock, reset_n - rising-edge clock, asynchronous active-low reset
//   key_n[3:0]     - raw digit buttons, active-low, bit i enters digit i
//   clear_n        - raw clear button, active-low
//   password_1/2   - captured digits
//   pw_valid       - complete code offered
//   pw_ack         - consumer accepts the offered code
//   digit_count    - digits held (0..2)
//   timeout_pulse  - one-cycle pulse when a partial entry times out
module parking_keypad_entry
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [KEY_COUNT-1:0] key_n,
    input  logic                 clear_n,
    output logic [DIGIT_W-1:0]   password_1,
    output logic [DIGIT_W-1:0]   password_2,
    output logic                 pw_valid,
    input  logic                 pw_ack,
    output logic [1:0]           digit_count,
    output logic                 timeout_pulse
);

    if (DEBOUNCE_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("parking_keypad_entry: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be nonzero");
    end

    state_t               state;
    state_t               next_state;
    logic [KEY_COUNT-1:0] key_ev;
    logic                 clear_ev;
    logic                 single_key;
    logic                 timeout_hit;

    for (genvar g = 0; g < KEY_COUNT; g++) begin : g_key_debounce
        parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_debounce (
            .clock   (clock),
            .reset_n (reset_n),
            .raw     (key_n[g]),
            .press   (key_ev[g])
        );
    end

    parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_debounce (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (clear_n),
        .press   (clear_ev)
    );

    // Simultaneous key events are ambiguous and all get dropped.
    assign single_key = $onehot(key_ev);

`ifdef KEYPAD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] idle_count;
    logic             key_any;

    assign key_any     = |key_ev;
    // Any key or clear event in the expiry cycle takes precedence.
    assign timeout_hit = (state == ONE) && (idle_count == TMO_W'(TIMEOUT_CYCLES))
                         && !key_any && !clear_ev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_count    <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= timeout_hit;
            if (state != ONE || key_any || clear_ev) begin
                idle_count <= '0;
            end else if (!timeout_hit) begin
                idle_count <= idle_count + 1'b1;
            end
        end
    end
`else
    assign timeout_hit   = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= EMPTY;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            EMPTY: begin
                if (clear_ev)        next_state = EMPTY;
                else if (single_key) next_state = ONE;
            end
            ONE: begin
                if (clear_ev)         next_state = EMPTY;
                else if (single_key)  next_state = FULL;
                else if (timeout_hit) next_state = EMPTY;
            end
            FULL: begin
                if (pw_ack) next_state = EMPTY;
            end
            default: next_state = EMPTY;
        endcase
    end

    always_comb begin
        pw_valid    = (state == FULL);
        digit_count = 2'd0;
        case (state)
            ONE:     digit_count = 2'd1;
            FULL:    digit_count = 2'd2;
            default: digit_count = 2'd0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            password_1 <= '0;
            password_2 <= '0;
        end else if (single_key && !clear_ev) begin
            if (state == EMPTY)    password_1 <= key_index(key_ev);
            else if (state == ONE) password_2 <= key_index(key_ev);
        end
    end

endmodule
